fb_mono_engine: RTL and testbench

Parametrised monochrome framebuffer engine: the next generation of the OLED framebuffer, with configurable resolution and a single valid/ready command port that serialises reads and writes. It supports horizontal and column access for both reads and writes, bitwise write ops, and edge clipping. It sits between the drawing/text logic and the OLED page streamer, and owns one dual-port BRAM.

---
 rtl/fb_pkg.sv | 40 ++++
 rtl/dual_port_bram.sv | 19 +
 rtl/fb_mono_engine.sv | 145 ++++++++++++++
 tb/tb_fb_mono_engine.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and the pixel-merge helper for the monochrome framebuffer engine.
package fb_pkg;

  typedef enum logic [1:0] {
    OP_COPY = 2'b00,
    OP_OR   = 2'b01,
    OP_ANDN = 2'b10,
    OP_XOR  = 2'b11
  } fb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } fb_state_e;

  typedef struct packed {
    logic       write;
    logic       col;
    fb_op_e     op;
    logic [7:0] data;
  } fb_cmd_t;

  // Only masked pixels change; everything outside m keeps the captured value.
  function automatic logic [7:0] fb_apply_op(input logic [7:0] b, input logic [7:0] m,
                                             input logic [7:0] d, input fb_op_e op);
    logic [7:0] bm, dm, f;
    bm = b & m;
    dm = d & m;
    case (op)
      OP_COPY: f = dm;
      OP_OR:   f = bm | dm;
      OP_ANDN: f = bm & ~dm;
      default: f = bm ^ dm;
    endcase
    return (b & ~m) | (f & m);
  endfunction

endpackage

// File: rtl/dual_port_bram.sv
// Simple dual-port block RAM: port A write-only, port B read-only, 1-cycle read latency.
module dual_port_bram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    b_rdata <= mem[b_addr];
  end
endmodule

// File: rtl/fb_mono_engine.sv
// Monochrome framebuffer engine: serial read / read-modify-write of 8-pixel
// horizontal spans or vertical columns with edge clipping, over one BRAM.
module fb_mono_engine
  import fb_pkg::*;
#(
  parameter int H_PIXELS = 128,
  parameter int V_PIXELS = 64,
  parameter int XW = $clog2(H_PIXELS),
  parameter int YW = $clog2(V_PIXELS),
  parameter int AW = $clog2(H_PIXELS / 8 * V_PIXELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_col,
  input  logic [1:0]    req_op,
  input  logic [XW-1:0] req_x,
  input  logic [YW-1:0] req_y,
  input  logic [7:0]    req_data,
  output logic          rsp_valid,
  output logic [7:0]    rsp_data,
  output logic          rsp_err
);
  localparam int BPR = H_PIXELS / 8;

  fb_state_e       state, state_n;
  fb_cmd_t         cmd;
  logic [XW-1:0]   x_r;
  logic [YW-1:0]   y_r;
  logic [3:0]      n_r, cnt, req_n;
  logic [7:0][7:0] cap, cap_fwd;
  logic            acc, req_err, req_skip_rd, a_we;
  logic [2:0]      xo;
  logic [AW-1:0]   beat_addr;
  logic [7:0]      a_wdata, b_rdata, wr_m, wr_d, rd_h, rd_c;
  logic [15:0]     h_mask, h_data, h_cat;
  int              rows_left;

  function automatic logic [AW-1:0] addr_of(input int row, input int col);
    return AW'(row * BPR + col);
  endfunction

  assign req_ready   = (state == ST_IDLE) && !rst;
  assign acc         = req_valid && req_ready;
  assign req_err     = ({1'b0, req_x} >= (XW+1)'(H_PIXELS)) || ({1'b0, req_y} >= (YW+1)'(V_PIXELS));
  assign req_skip_rd = req_write && !req_col && (req_op == 2'b00) && (req_x[2:0] == 3'd0);
  assign xo          = x_r[2:0];

  // Beat count: columns clip at the bottom edge, spans drop the right byte at the right edge.
  always_comb begin
    rows_left = V_PIXELS - int'(req_y);
    if (req_col) req_n = (rows_left > 8) ? 4'd8 : 4'(rows_left);
    else         req_n = (req_x[2:0] != 3'd0 && int'(req_x[XW-1:3]) + 1 < BPR) ? 4'd2 : 4'd1;
  end

  assign beat_addr = cmd.col ? addr_of(int'(y_r) + int'(cnt), int'(x_r[XW-1:3]))
                             : addr_of(int'(y_r), int'(x_r[XW-1:3]) + int'(cnt));

  // Last read beat is forwarded straight from the BRAM so the response can register on time.
  always_comb begin
    cap_fwd = cap;
    if (state == ST_RD && cnt != 4'd0) cap_fwd[3'(cnt - 4'd1)] = b_rdata;
  end

  always_comb begin
    h_mask = 16'hFF00 >> xo;
    h_data = {cmd.data, 8'h00} >> xo;
    if (cmd.col) begin
      wr_m = 8'h80 >> xo;
      wr_d = cmd.data[~cnt[2:0]] ? wr_m : 8'h00;
    end else begin
      wr_m = cnt[0] ? h_mask[7:0] : h_mask[15:8];
      wr_d = cnt[0] ? h_data[7:0] : h_data[15:8];
    end
  end

  assign a_wdata = fb_apply_op(cap[cnt[2:0]], wr_m, wr_d, cmd.op);

  always_comb begin
    h_cat = {cap_fwd[0], (n_r == 4'd2) ? cap_fwd[1] : 8'h00} << xo;
    rd_h  = h_cat[15:8];
    rd_c  = 8'h00;
    for (int i = 0; i < 8; i++)
      rd_c[7-i] = (4'(i) < n_r) ? cap_fwd[i][~xo] : 1'b0;
  end

  always_comb begin
    state_n = state;
    a_we    = 1'b0;
    case (state)
      ST_IDLE: if (acc) state_n = req_err ? ST_RESP : (req_skip_rd ? ST_WR : ST_RD);
      ST_RD:   if (cnt == n_r) state_n = cmd.write ? ST_WR : ST_RESP;
      ST_WR: begin
        a_we = 1'b1;
        if (cnt == n_r - 4'd1) state_n = ST_RESP;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cmd       <= '0;
      x_r       <= '0;
      y_r       <= '0;
      n_r       <= '0;
      cap       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)                      cnt <= 4'd0;
      else if (state == ST_RD || state == ST_WR) cnt <= cnt + 4'd1;
      cap <= cap_fwd;
      if (acc) begin
        cmd.write <= req_write;
        cmd.col   <= req_col;
        cmd.op    <= fb_op_e'(req_op);
        cmd.data  <= req_data;
        x_r       <= req_x;
        y_r       <= req_y;
        n_r       <= req_n;
      end
      rsp_valid <= (state_n == ST_RESP);
      if (state_n == ST_RESP) begin
        rsp_err  <= (state == ST_IDLE);
        rsp_data <= (state == ST_RD) ? (cmd.col ? rd_c : rd_h) : 8'h00;
      end
    end
  end

  dual_port_bram #(.DW(8), .AW(AW)) u_bram (
    .clk     (clk),
    .a_we    (a_we),
    .a_addr  (beat_addr),
    .a_wdata (a_wdata),
    .b_addr  (beat_addr),
    .b_rdata (b_rdata)
  );
endmodule

// File: tb/tb_fb_mono_engine.sv
// Directed bench: default 128x64 engine plus a 96x40 engine for clipping and range errors.
module tb_fb_mono_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, v0, v1, rdy0, rdy1, rv0, rv1, re0, re1;
  logic       req_write, req_col;
  logic [1:0] req_op;
  logic [6:0] req_x;
  logic [5:0] req_y;
  logic [7:0] req_data, rd0, rd1;

  localparam logic [1:0] OC = 2'b00, OO = 2'b01, OA = 2'b10, OX = 2'b11;

  fb_mono_engine #(.H_PIXELS(128), .V_PIXELS(64)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_write(req_write),
    .req_col(req_col), .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_data(req_data),
    .rsp_valid(rv0), .rsp_data(rd0), .rsp_err(re0));

  fb_mono_engine #(.H_PIXELS(96), .V_PIXELS(40)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
    .req_col(req_col), .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_data(req_data),
    .rsp_valid(rv1), .rsp_data(rd1), .rsp_err(re1));

  typedef struct {
    bit         dut;
    logic       w;
    logic       col;
    logic [1:0] op;
    logic [6:0] x;
    logic [5:0] y;
    logic [7:0] d;
    logic [7:0] exp_d;
    logic       exp_e;
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input bit dut, input logic w, input logic col, input logic [1:0] op,
                              input int x, input int y, input logic [7:0] d, input logic [7:0] exp_d,
                              input logic exp_e, input int exp_lat);
    vec_t v;
    v.dut = dut; v.w = w; v.col = col; v.op = op; v.x = 7'(x); v.y = 6'(y);
    v.d = d; v.exp_d = exp_d; v.exp_e = exp_e; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Called at a negedge; lat counts cycles from accept edge T to the rsp_valid cycle.
  task automatic run_cmd(input bit which, input logic w, input logic col, input logic [1:0] op,
                         input logic [6:0] x, input logic [5:0] y, input logic [7:0] d,
                         output logic [7:0] rd, output logic er, output int lat);
    int k;
    lat = -1; rd = 8'h00; er = 1'b0; k = 0;
    while (!(which ? rdy1 : rdy0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) return;
    req_write = w; req_col = col; req_op = op; req_x = x; req_y = y; req_data = d;
    if (which) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    req_data = 8'h5A; req_x = 7'h7F; req_y = 6'h3F;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (which ? rv1 : rv0) begin
        lat = c;
        rd  = which ? rd1 : rd0;
        er  = which ? re1 : re0;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    int         lat, seen;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    req_write = 1'b0; req_col = 1'b0; req_op = OC; req_x = '0; req_y = '0; req_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready0", 0, int'(rdy0), 0);
    chk("rst_ready1", 0, int'(rdy1), 0);
    chk("rst_valid0", 0, int'(rv0), 0);
    chk("rst_data0", 0, int'(rd0), 0);
    chk("rst_err0", 0, int'(re0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst0", 0, int'(rdy0), 1);
    chk("ready_after_rst1", 0, int'(rdy1), 1);

    //               dut w  col op   x    y   d      exp_d  e  lat
    vecs.push_back(mk(0, 1, 0, OC,   0,   0, 8'h00, 8'h00, 0, 2));
    vecs.push_back(mk(0, 1, 0, OC,   8,   0, 8'hA5, 8'h00, 0, 2));
    vecs.push_back(mk(0, 0, 0, OC,   8,   0, 8'h00, 8'hA5, 0, 3));
    vecs.push_back(mk(0, 1, 0, OC,   0,  10, 8'h00, 8'h00, 0, 2));
    vecs.push_back(mk(0, 1, 0, OC,   8,  10, 8'h00, 8'h00, 0, 2));
    vecs.push_back(mk(0, 1, 0, OC,   3,  10, 8'hFF, 8'h00, 0, 6));
    vecs.push_back(mk(0, 0, 0, OC,   0,  10, 8'h00, 8'h1F, 0, 3));
    vecs.push_back(mk(0, 0, 0, OC,   8,  10, 8'h00, 8'hE0, 0, 3));
    vecs.push_back(mk(0, 0, 0, OC,   3,  10, 8'h00, 8'hFF, 0, 4));
    vecs.push_back(mk(0, 1, 1, OC,   5,  56, 8'h00, 8'h00, 0, 18));
    vecs.push_back(mk(0, 1, 1, OO,   5,  60, 8'hFF, 8'h00, 0, 10));
    vecs.push_back(mk(0, 0, 1, OC,   5,  56, 8'h00, 8'h0F, 0, 10));
    vecs.push_back(mk(0, 0, 1, OC,   5,  60, 8'h00, 8'hF0, 0, 6));
    vecs.push_back(mk(0, 1, 0, OC,   0,   0, 8'h3C, 8'h00, 0, 2));
    vecs.push_back(mk(0, 1, 0, OX,   0,   0, 8'hF0, 8'h00, 0, 4));
    vecs.push_back(mk(0, 0, 0, OC,   0,   0, 8'h00, 8'hCC, 0, 3));
    vecs.push_back(mk(0, 1, 0, OX,   0,   0, 8'hF0, 8'h00, 0, 4));
    vecs.push_back(mk(0, 0, 0, OC,   0,   0, 8'h00, 8'h3C, 0, 3));
    vecs.push_back(mk(0, 1, 0, OC,   0,   0, 8'hFF, 8'h00, 0, 2));
    vecs.push_back(mk(0, 1, 0, OA,   0,   0, 8'h80, 8'h00, 0, 4));
    vecs.push_back(mk(0, 0, 0, OC,   0,   0, 8'h00, 8'h7F, 0, 3));
    vecs.push_back(mk(0, 0, 0, OC,   8,   0, 8'h00, 8'hA5, 0, 3));
    vecs.push_back(mk(0, 1, 0, OC, 120,   5, 8'hFF, 8'h00, 0, 2));
    vecs.push_back(mk(0, 0, 0, OC, 125,   5, 8'h00, 8'hE0, 0, 3));
    vecs.push_back(mk(0, 1, 0, OC, 125,   5, 8'h00, 8'h00, 0, 4));
    vecs.push_back(mk(0, 0, 0, OC, 120,   5, 8'h00, 8'hF8, 0, 3));
    vecs.push_back(mk(0, 1, 0, OA,   4,  10, 8'hFF, 8'h00, 0, 6));
    vecs.push_back(mk(0, 0, 0, OC,   0,  10, 8'h00, 8'h10, 0, 3));
    vecs.push_back(mk(0, 0, 0, OC,   8,  10, 8'h00, 8'h00, 0, 3));
    vecs.push_back(mk(1, 1, 0, OC,  88,   3, 8'h00, 8'h00, 0, 2));
    vecs.push_back(mk(1, 1, 0, OC,   0,   4, 8'h55, 8'h00, 0, 2));
    vecs.push_back(mk(1, 1, 0, OC,  32,   2, 8'h33, 8'h00, 0, 2));
    vecs.push_back(mk(1, 1, 0, OC,  92,   3, 8'hFF, 8'h00, 0, 4));
    vecs.push_back(mk(1, 0, 0, OC,  88,   3, 8'h00, 8'h0F, 0, 3));
    vecs.push_back(mk(1, 0, 0, OC,   0,   4, 8'h00, 8'h55, 0, 3));
    vecs.push_back(mk(1, 0, 0, OC,  92,   3, 8'h00, 8'hF0, 0, 3));
    vecs.push_back(mk(1, 1, 0, OC,   0,  45, 8'hAA, 8'h00, 1, 1));
    vecs.push_back(mk(1, 0, 0, OC,   0,  45, 8'h00, 8'h00, 1, 1));
    vecs.push_back(mk(1, 1, 0, OC, 100,   0, 8'hAA, 8'h00, 1, 1));
    vecs.push_back(mk(1, 0, 0, OC,  32,   2, 8'h00, 8'h33, 0, 3));
    vecs.push_back(mk(1, 0, 0, OC,   0,   4, 8'h00, 8'h55, 0, 3));
    vecs.push_back(mk(1, 1, 1, OC,   7,  36, 8'hFF, 8'h00, 0, 10));
    vecs.push_back(mk(1, 0, 1, OC,   7,  36, 8'h00, 8'hF0, 0, 6));
    vecs.push_back(mk(1, 0, 1, OC,   7,  38, 8'h00, 8'hC0, 0, 4));

    foreach (vecs[i]) begin
      run_cmd(vecs[i].dut, vecs[i].w, vecs[i].col, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].d, d, e, lat);
      chk("rsp_data", i, int'(d), int'(vecs[i].exp_d));
      chk("rsp_err", i, int'(e), int'(vecs[i].exp_e));
      chk("latency", i, lat, vecs[i].exp_lat);
    end

    // rsp_data holds between responses
    run_cmd(0, 0, 0, OC, 7'd8, 6'd0, 8'h00, d, e, lat);
    chk("hold_pre", 0, int'(d), 8'hA5);
    repeat (3) @(negedge clk);
    chk("hold_data", 0, int'(rd0), 8'hA5);
    chk("hold_valid", 0, int'(rv0), 0);

    // reset in the middle of a column RMW: aborts silently
    req_write = 1'b1; req_col = 1'b1; req_op = OO; req_x = 7'd5; req_y = 6'd56; req_data = 8'h00;
    v0 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_in_rst", 0, int'(rdy0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 0, int'(rdy0), 1);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (rv0) seen++;
      @(negedge clk);
    end
    chk("no_rsp_after_abort", 0, seen, 0);
    run_cmd(0, 0, 0, OC, 7'd8, 6'd0, 8'h00, d, e, lat);
    chk("post_abort_data", 0, int'(d), 8'hA5);
    chk("post_abort_lat", 0, lat, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
